// File: rtl/decoder_round_controller.sv
// Round sequencer for the X-stabilizer decoding grid: loads a syndrome frame, times the
// offer window, then scans every node and streams (node, match) results for defect nodes.
module decoder_round_controller #(
  parameter int  ROWS              = 4,
  parameter int  COLS              = 5,
  parameter int  CORDINATE_WIDTH   = 3,
  parameter int  SETTLE_CYCLES     = 100,
  parameter int  OFFER_CYCLES      = 2500,
  localparam int MATCH_VALUE_WIDTH = 2 * CORDINATE_WIDTH,
  localparam int NODES             = ROWS * COLS
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NODES-1:0]                   syndrome_in,
  input  logic                               syndrome_valid,
  output logic                               syndrome_ready,
  output logic [NODES-1:0]                   grid_meas_value,
  output logic                               grid_meas_valid,
  output logic                               start_offer,
  output logic                               stop_offer,
  input  logic [NODES-1:0]                   grid_measurement,
  input  logic [NODES*MATCH_VALUE_WIDTH-1:0] grid_match_value,
  output logic                               result_valid,
  input  logic                               result_ready,
  output logic [CORDINATE_WIDTH-1:0]         result_y,
  output logic [CORDINATE_WIDTH-1:0]         result_x,
  output logic [MATCH_VALUE_WIDTH-1:0]       result_match,
  output logic                               round_done,
  output logic                               busy
);

  localparam int CNT_MAX = (SETTLE_CYCLES > OFFER_CYCLES) ? SETTLE_CYCLES : OFFER_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W   = (NODES > 1) ? $clog2(NODES) : 1;

  localparam logic [CNT_W-1:0]           SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]           OFFER_LAST  = CNT_W'(OFFER_CYCLES - 1);
  localparam logic [IDX_W-1:0]           IDX_LAST    = IDX_W'(NODES - 1);
  localparam logic [CORDINATE_WIDTH-1:0] COL_LAST    = CORDINATE_WIDTH'(COLS - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    OFFER,
    STOP,
    SCAN,
    DONE
  } state_t;

  state_t                     state;
  logic [CNT_W-1:0]           cnt;
  logic [IDX_W-1:0]           idx;
  logic [CORDINATE_WIDTH-1:0] row;
  logic [CORDINATE_WIDTH-1:0] col;
  logic                       scan_advance;

  assign busy = (state != IDLE);

  // A node is finished when it is a non-defect, or its result word has just been taken.
  assign scan_advance = (state == SCAN) &&
                        (result_valid ? result_ready : !grid_measurement[idx]);

  // NOTE: every register here uses non-blocking assignments so that all of them update
  // together at the clock edge, independent of statement order inside the block.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the frame register is an ordinary register, not a memory, so it is cleared
      // with everything else; grid_meas_value doubles as that frame register.
      state           <= IDLE;
      cnt             <= '0;
      idx             <= '0;
      row             <= '0;
      col             <= '0;
      syndrome_ready  <= 1'b0;
      grid_meas_value <= '0;
      grid_meas_valid <= 1'b0;
      start_offer     <= 1'b0;
      stop_offer      <= 1'b0;
      result_valid    <= 1'b0;
      result_y        <= '0;
      result_x        <= '0;
      result_match    <= '0;
      round_done      <= 1'b0;
    end else begin
      grid_meas_valid <= 1'b0;
      start_offer     <= 1'b0;
      stop_offer      <= 1'b0;
      round_done      <= 1'b0;

      unique case (state)
        IDLE: begin
          syndrome_ready <= 1'b1;
          if (syndrome_valid && syndrome_ready) begin
            grid_meas_value <= syndrome_in;
            grid_meas_valid <= 1'b1;
            syndrome_ready  <= 1'b0;
            state           <= LOAD;
          end
        end

        LOAD: begin
          cnt   <= '0;
          state <= SETTLE;
        end

        SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            cnt         <= '0;
            start_offer <= 1'b1;
            state       <= OFFER;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        OFFER: begin
          if (cnt == OFFER_LAST) begin
            cnt        <= '0;
            stop_offer <= 1'b1;
            state      <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        STOP: begin
          idx   <= '0;
          row   <= '0;
          col   <= '0;
          state <= SCAN;
        end

        SCAN: begin
          if (!result_valid && grid_measurement[idx]) begin
            result_valid <= 1'b1;
            result_y     <= row;
            result_x     <= col;
            result_match <= grid_match_value[idx*MATCH_VALUE_WIDTH +: MATCH_VALUE_WIDTH];
          end
          if (scan_advance) begin
            result_valid <= 1'b0;
            if (idx == IDX_LAST) begin
              round_done <= 1'b1;
              state      <= DONE;
            end else begin
              idx <= idx + 1'b1;
              // row/col shadow idx so no divider is needed for the coordinates.
              if (col == COL_LAST) begin
                col <= '0;
                row <= row + 1'b1;
              end else begin
                col <= col + 1'b1;
              end
            end
          end
        end

        DONE: begin
          syndrome_ready <= 1'b1;
          state          <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_round_controller.sv
// Bench for decoder_round_controller: a small grid model plus a result scoreboard that is
// filled when a frame is sent and drained when the controller hands out result words.
module tb_decoder_round_controller;

  localparam int ROWS  = 4;
  localparam int COLS  = 5;
  localparam int CW    = 3;
  localparam int MVW   = 2 * CW;
  localparam int NODES = ROWS * COLS;

  // Defects at (1,0),(1,1),(2,2),(2,3),(3,0) -> bits 5,6,12,13,15.
  localparam logic [NODES-1:0] FRAME_MAIN    = 20'h0B060;
  // Defects at the first and last node, (0,0) and (3,4).
  localparam logic [NODES-1:0] FRAME_CORNERS = 20'h80001;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NODES-1:0]       syndrome_in;
  logic                   syndrome_valid;
  logic                   syndrome_ready;
  logic [NODES-1:0]       grid_meas_value;
  logic                   grid_meas_valid;
  logic                   start_offer;
  logic                   stop_offer;
  logic [NODES-1:0]       grid_measurement;
  logic [NODES*MVW-1:0]   grid_match_value;
  logic                   result_valid;
  logic                   result_ready;
  logic [CW-1:0]          result_y;
  logic [CW-1:0]          result_x;
  logic [MVW-1:0]         result_match;
  logic                   round_done;
  logic                   busy;

  decoder_round_controller #(
    .ROWS            (ROWS),
    .COLS            (COLS),
    .CORDINATE_WIDTH (CW),
    .SETTLE_CYCLES   (100),
    .OFFER_CYCLES    (2500)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .syndrome_in      (syndrome_in),
    .syndrome_valid   (syndrome_valid),
    .syndrome_ready   (syndrome_ready),
    .grid_meas_value  (grid_meas_value),
    .grid_meas_valid  (grid_meas_valid),
    .start_offer      (start_offer),
    .stop_offer       (stop_offer),
    .grid_measurement (grid_measurement),
    .grid_match_value (grid_match_value),
    .result_valid     (result_valid),
    .result_ready     (result_ready),
    .result_y         (result_y),
    .result_x         (result_x),
    .result_match     (result_match),
    .round_done       (round_done),
    .busy             (busy)
  );

  initial forever #5 clk = ~clk;

  typedef struct packed {
    logic [CW-1:0]  y;
    logic [CW-1:0]  x;
    logic [MVW-1:0] m;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_load = 0, n_start = 0, n_stop = 0, n_done = 0, n_results = 0, n_valid_cycles = 0;
  int t_accept = 0, t_start = 0, t_stop = 0, t_done = 0;

  // Partner pairs used by the grid model for the main frame; any other defect matches itself.
  function automatic logic [MVW-1:0] partner(input int i);
    case (i)
      5:       return {3'd1, 3'd1};
      6:       return {3'd1, 3'd0};
      12:      return {3'd2, 3'd3};
      13:      return {3'd2, 3'd2};
      default: return {3'(i / COLS), 3'(i % COLS)};
    endcase
  endfunction

  // Grid model: latches the frame on the load pulse; non-defect nodes carry junk matches.
  logic [NODES-1:0] grid_frame = '0;
  always @(posedge clk) if (grid_meas_valid) grid_frame <= grid_meas_value;

  always_comb begin
    grid_measurement = grid_frame;
    grid_match_value = '0;
    for (int i = 0; i < NODES; i++)
      grid_match_value[i*MVW +: MVW] = grid_frame[i] ? partner(i) : MVW'(~i);
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor and scoreboard drain, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (syndrome_valid && syndrome_ready) t_accept = cyc + 1;
    if (grid_meas_valid) n_load++;
    if (start_offer) begin n_start++; t_start = cyc; end
    if (stop_offer)  begin n_stop++;  t_stop  = cyc; end
    if (round_done)  begin n_done++;  t_done  = cyc; end
    if (result_valid) n_valid_cycles++;
    if (result_valid && result_ready) begin
      n_results++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL result_unexpected: got y=%0d x=%0d match=%0h, expected no result",
                 result_y, result_x, result_match);
      end else begin
        e = exp_q.pop_front();
        if ({result_y, result_x, result_match} !== e) begin
          n_fail++;
          $display("FAIL result_word: got y=%0d x=%0d match=%0h, expected y=%0d x=%0d match=%0h",
                   result_y, result_x, result_match, e.y, e.x, e.m);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic void push_expected(input logic [NODES-1:0] frame);
    exp_t e;
    for (int i = 0; i < NODES; i++) begin
      if (frame[i]) begin
        e.y = 3'(i / COLS);
        e.x = 3'(i % COLS);
        e.m = partner(i);
        exp_q.push_back(e);
      end
    end
  endfunction

  task automatic start_frame(input logic [NODES-1:0] frame, input bit hold);
    int k;
    k = 0;
    while (!syndrome_ready && k < 200) begin tick(1); k++; end
    if (!syndrome_ready) begin
      n_checks++; n_fail++;
      $display("FAIL ready_timeout: syndrome_ready=0 after 200 cycles, expected 1");
    end
    syndrome_in    = frame;
    syndrome_valid = 1'b1;
    push_expected(frame);
    tick(1);
    if (!hold) syndrome_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0, k;
    d0 = n_done;
    k  = 0;
    while (n_done == d0 && k < budget) begin tick(1); k++; end
    n_checks++;
    if (n_done == d0) begin
      n_fail++;
      $display("FAIL round_done_timeout: no round_done within %0d cycles", budget);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; syndrome_in = '0; syndrome_valid = 1'b0; result_ready = 1'b0;
    #2 reset = 1'b0;
    tick(10);
    n_checks++;
    if ({syndrome_ready, grid_meas_valid, start_offer, stop_offer, result_valid, round_done, busy} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_controls: got %b expected 0000000",
               {syndrome_ready, grid_meas_valid, start_offer, stop_offer, result_valid, round_done, busy});
    end
    n_checks++;
    if ({grid_meas_value, result_y, result_x, result_match} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got %0h expected 0", {grid_meas_value, result_y, result_x, result_match});
    end
    reset = 1'b1;
    tick(2);
    n_checks++;
    if (syndrome_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got ready=%b busy=%b expected ready=1 busy=0", syndrome_ready, busy);
    end
  endtask

  task automatic test_timing_readout();
    int l0, s0, p0, d0, r0;
    l0 = n_load; s0 = n_start; p0 = n_stop; d0 = n_done; r0 = n_results;
    result_ready = 1'b1;
    start_frame(FRAME_MAIN, 1'b0);
    wait_done(4000);
    n_checks++;
    if (n_load - l0 !== 1) begin
      n_fail++; $display("FAIL load_pulses: got %0d expected 1", n_load - l0);
    end
    n_checks++;
    if (grid_meas_value !== FRAME_MAIN) begin
      n_fail++; $display("FAIL meas_value: got %0h expected %0h", grid_meas_value, FRAME_MAIN);
    end
    n_checks++;
    if (n_start - s0 !== 1 || t_start - t_accept !== 101) begin
      n_fail++; $display("FAIL start_latency: got %0d pulses, %0d cycles; expected 1 pulse, 101 cycles",
                         n_start - s0, t_start - t_accept);
    end
    n_checks++;
    if (n_stop - p0 !== 1 || t_stop - t_start !== 2500) begin
      n_fail++; $display("FAIL offer_window: got %0d pulses, %0d cycles; expected 1 pulse, 2500 cycles",
                         n_stop - p0, t_stop - t_start);
    end
    n_checks++;
    if (n_results - r0 !== 5 || exp_q.size() !== 0) begin
      n_fail++; $display("FAIL result_count: got %0d (%0d pending) expected 5 (0 pending)",
                         n_results - r0, exp_q.size());
    end
    tick(1);
    n_checks++;
    if (n_done - d0 !== 1 || busy !== 1'b0 || syndrome_ready !== 1'b1) begin
      n_fail++; $display("FAIL round_end: got done=%0d busy=%b ready=%b expected done=1 busy=0 ready=1",
                         n_done - d0, busy, syndrome_ready);
    end
  endtask

  task automatic test_backpressure();
    int r0, k;
    exp_t e2;
    r0 = n_results;
    result_ready = 1'b1;
    start_frame(FRAME_MAIN, 1'b0);
    k = 0;
    while (n_results == r0 && k < 4000) begin tick(1); k++; end
    result_ready = 1'b0;
    k = 0;
    while (!result_valid && k < 50) begin tick(1); k++; end
    e2 = (exp_q.size() > 0) ? exp_q[0] : '0;
    for (int c = 0; c < 7; c++) begin
      n_checks++;
      if (result_valid !== 1'b1 || {result_y, result_x, result_match} !== e2 || n_results - r0 !== 1) begin
        n_fail++;
        $display("FAIL stall_hold: cycle %0d got valid=%b y=%0d x=%0d match=%0h taken=%0d, expected valid=1 y=%0d x=%0d match=%0h taken=1",
                 c, result_valid, result_y, result_x, result_match, n_results - r0, e2.y, e2.x, e2.m);
      end
      tick(1);
    end
    result_ready = 1'b1;
    wait_done(200);
    n_checks++;
    if (n_results - r0 !== 5 || exp_q.size() !== 0) begin
      n_fail++; $display("FAIL stall_count: got %0d (%0d pending) expected 5 (0 pending)",
                         n_results - r0, exp_q.size());
    end
  endtask

  task automatic test_zero_frame();
    int v0;
    v0 = n_valid_cycles;
    result_ready = 1'b1;
    start_frame('0, 1'b0);
    wait_done(4000);
    n_checks++;
    if (n_valid_cycles !== v0) begin
      n_fail++; $display("FAIL zero_results: got %0d valid cycles expected 0", n_valid_cycles - v0);
    end
    n_checks++;
    if (t_done - (t_stop + 1) !== 20) begin
      n_fail++; $display("FAIL zero_scan_time: got %0d cycles expected 20", t_done - (t_stop + 1));
    end
    n_checks++;
    if (busy !== 1'b0 || syndrome_ready !== 1'b1) begin
      n_fail++; $display("FAIL zero_idle: got busy=%b ready=%b expected busy=0 ready=1", busy, syndrome_ready);
    end
  endtask

  task automatic test_mid_reset();
    int s0, p0, v0, d0, r0, k;
    s0 = n_start;
    result_ready = 1'b1;
    start_frame(FRAME_MAIN, 1'b0);
    k = 0;
    while (n_start == s0 && k < 300) begin tick(1); k++; end
    tick(1000);
    #1 reset = 1'b0;
    #1;
    n_checks++;
    if ({syndrome_ready, grid_meas_value, grid_meas_valid, start_offer, stop_offer, result_valid,
         result_y, result_x, result_match, round_done, busy} !== '0) begin
      n_fail++;
      $display("FAIL abort_outputs: got ready=%b busy=%b value=%0h expected all 0",
               syndrome_ready, busy, grid_meas_value);
    end
    exp_q.delete();
    tick(3);
    reset = 1'b1;
    p0 = n_stop; v0 = n_valid_cycles; d0 = n_done;
    tick(3000);
    n_checks++;
    if (n_stop !== p0 || n_valid_cycles !== v0 || n_done !== d0) begin
      n_fail++; $display("FAIL abort_residue: got stop=%0d valid=%0d done=%0d expected 0 0 0",
                         n_stop - p0, n_valid_cycles - v0, n_done - d0);
    end
    r0 = n_results;
    start_frame(FRAME_MAIN, 1'b0);
    wait_done(4000);
    n_checks++;
    if (n_results - r0 !== 5 || exp_q.size() !== 0) begin
      n_fail++; $display("FAIL after_abort_round: got %0d (%0d pending) expected 5 (0 pending)",
                         n_results - r0, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int l0, r0, td, k;
    l0 = n_load; r0 = n_results;
    result_ready = 1'b1;
    start_frame(FRAME_MAIN, 1'b1);
    syndrome_in = FRAME_CORNERS;
    push_expected(FRAME_CORNERS);
    wait_done(4000);
    n_checks++;
    if (n_load - l0 !== 1) begin
      n_fail++; $display("FAIL busy_ignores_valid: got %0d loads expected 1", n_load - l0);
    end
    td = t_done;
    k = 0;
    while (!busy && k < 10) begin tick(1); k++; end
    syndrome_valid = 1'b0;
    n_checks++;
    if (t_accept - td !== 2) begin
      n_fail++; $display("FAIL held_frame_accept: got %0d cycles after done expected 2", t_accept - td);
    end
    wait_done(4000);
    n_checks++;
    if (n_results - r0 !== 7 || exp_q.size() !== 0 || grid_meas_value !== FRAME_CORNERS) begin
      n_fail++; $display("FAIL back_to_back: got %0d results (%0d pending) value=%0h expected 7 (0 pending) value=%0h",
                         n_results - r0, exp_q.size(), grid_meas_value, FRAME_CORNERS);
    end
  endtask

  initial begin
    test_reset();
    test_timing_readout();
    test_backpressure();
    test_zero_frame();
    test_mid_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
